// File: rtl/sti_load_sched.sv
// Round-robin scheduler sharing one STI/DAC serializer between requesters A and B.
// Latches a descriptor per transfer, pulses load for one cycle, waits for the
// serializer to start and finish (so_valid), enforces an idle gap, and raises a
// sticky pi_end once both requesters have signalled end-of-stream.
`timescale 1ns / 1ps

module sti_load_sched #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [15:0] a_data,
  input  logic [1:0]  a_len,
  input  logic        a_msb,
  input  logic        a_low,
  input  logic        a_fill,
  input  logic        a_end,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [15:0] b_data,
  input  logic [1:0]  b_len,
  input  logic        b_msb,
  input  logic        b_low,
  input  logic        b_fill,
  input  logic        b_end,
  output logic        b_ack,
  input  logic        so_valid,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_fill,
  output logic        pi_end,
  output logic        busy,
  output logic        grant_id,
  output logic        err_timeout,
  output logic [7:0]  tx_count
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd2;
  localparam logic [2:0] ST_GAP        = 3'd3;
  localparam logic [2:0] ST_END        = 3'd4;

  // Descriptor packing: {data, length, msb, low, fill}
  logic [20:0] pi_d, pi_q;
  logic [2:0]  state_d, state_q;
  logic        last_d, last_q;
  logic        end_a_d, end_a_q, end_b_d, end_b_q;
  logic [3:0]  gap_d, gap_q;
  logic [7:0]  wd_d, wd_q;
  logic        load_d, load_q;
  logic        a_ack_d, a_ack_q, b_ack_d, b_ack_q;
  logic        pi_end_d, pi_end_q;
  logic        busy_d, busy_q;
  logic        grant_d, grant_q;
  logic        err_d, err_q;
  logic [7:0]  tx_d, tx_q;
  logic        win_b;

  // With both requesting, the side that did not win last time goes next.
  assign win_b = b_req & (~a_req | ~last_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    pi_d     = pi_q;
    last_d   = last_q;
    end_a_d  = end_a_q | a_end;
    end_b_d  = end_b_q | b_end;
    gap_d    = gap_q;
    wd_d     = wd_q;
    load_d   = 1'b0;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    pi_end_d = pi_end_q;
    grant_d  = grant_q;
    err_d    = err_q;
    tx_d     = tx_q;
    case (state_q)
      ST_IDLE: begin
        // Pending requests are served before end-of-stream is signalled.
        if (a_req || b_req) begin
          pi_d    = win_b ? {b_data, b_len, b_msb, b_low, b_fill}
                          : {a_data, a_len, a_msb, a_low, a_fill};
          load_d  = 1'b1;
          a_ack_d = ~win_b;
          b_ack_d = win_b;
          grant_d = win_b;
          last_d  = win_b;
          wd_d    = 8'd0;
          state_d = ST_WAIT_START;
        end else if (end_a_q && end_b_q) begin
          pi_end_d = 1'b1;
          state_d  = ST_END;
        end
      end
      ST_WAIT_START: begin
        if (so_valid) begin
          wd_d    = 8'd0;
          state_d = ST_WAIT_DONE;
        end else if (wd_q == 8'(TIMEOUT - 1)) begin
          wd_d    = 8'd0;
          err_d   = 1'b1;
          gap_d   = 4'd0;
          state_d = ST_GAP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!so_valid) begin
          tx_d    = tx_q + 8'd1;
          gap_d   = 4'd0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'(GAP_CYCLES - 1)) begin
          gap_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_END);
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pi_q     <= '0;
      last_q   <= 1'b1;
      end_a_q  <= 1'b0;
      end_b_q  <= 1'b0;
      gap_q    <= '0;
      wd_q     <= '0;
      load_q   <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      pi_end_q <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= 1'b0;
      err_q    <= 1'b0;
      tx_q     <= '0;
    end else begin
      state_q  <= state_d;
      pi_q     <= pi_d;
      last_q   <= last_d;
      end_a_q  <= end_a_d;
      end_b_q  <= end_b_d;
      gap_q    <= gap_d;
      wd_q     <= wd_d;
      load_q   <= load_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      pi_end_q <= pi_end_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      err_q    <= err_d;
      tx_q     <= tx_d;
    end
  end

  assign {pi_data, pi_length, pi_msb, pi_low, pi_fill} = pi_q;
  assign load        = load_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign pi_end      = pi_end_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;
  assign tx_count    = tx_q;

endmodule

// File: tb/tb_sti_load_sched.sv
// Scoreboard bench for sti_load_sched: stimulus pushes predicted grants, a monitor
// pops and compares on every load pulse, and a serializer model drives so_valid.
`timescale 1ns / 1ps

module tb_sti_load_sched;

  localparam int GAP = 1;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_msb, a_low, a_fill, a_end, a_ack;
  logic        b_req, b_msb, b_low, b_fill, b_end, b_ack;
  logic [15:0] a_data, b_data, pi_data;
  logic [1:0]  a_len, b_len, pi_length;
  logic        so_valid, load, pi_msb, pi_low, pi_fill, pi_end, busy, grant_id, err_timeout;
  logic [7:0]  tx_count;

  sti_load_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_data(a_data), .a_len(a_len), .a_msb(a_msb), .a_low(a_low),
    .a_fill(a_fill), .a_end(a_end), .a_ack(a_ack),
    .b_req(b_req), .b_data(b_data), .b_len(b_len), .b_msb(b_msb), .b_low(b_low),
    .b_fill(b_fill), .b_end(b_end), .b_ack(b_ack),
    .so_valid(so_valid), .load(load), .pi_data(pi_data), .pi_length(pi_length),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_fill(pi_fill), .pi_end(pi_end), .busy(busy),
    .grant_id(grant_id), .err_timeout(err_timeout), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          who;   // 0 = A, 1 = B
    logic [20:0] desc;
    int          cyc;   // expected monitor cycle, -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  bit   last_g  = 1'b1;
  int   exp_tx  = 0;
  bit   exp_err = 1'b0;
  int   ser_mode = 0;  // 0 random, 1 never starts, 2 always starts
  bit   ser_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor ----------------
  exp_t        e;
  logic [20:0] cur_pi = '0;
  logic        prev_load = 1'b0;
  int          loads_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cur_pi    = '0;
        prev_load = 1'b0;
      end else begin
        if (load) begin
          loads_seen++;
          check("load_single_cycle", prev_load, 0);
          if (exp_q.size() == 0) begin
            check("load_expected", load, 0);
          end else begin
            e = exp_q.pop_front();
            check("ack_a", a_ack, !e.who);
            check("ack_b", b_ack, e.who);
            check("grant_id", grant_id, e.who);
            check("pi_desc", {pi_data, pi_length, pi_msb, pi_low, pi_fill}, e.desc);
            if (e.cyc >= 0) check("req_to_load_latency", cyc, e.cyc);
            check("tx_at_issue", tx_count, 8'(exp_tx));
            check("err_at_issue", err_timeout, exp_err);
            check("pi_end_at_issue", pi_end, 0);
            cur_pi = e.desc;
          end
        end else if (a_ack || b_ack) begin
          check("ack_without_load", {a_ack, b_ack}, 0);
        end
        check("pi_held", {pi_data, pi_length, pi_msb, pi_low, pi_fill}, cur_pi);
        prev_load = load;
      end
    end
  end

  // ---------------- serializer model ----------------
  task automatic run_ser();
    bit silent;
    int nbits, d, ngap;
    silent = (ser_mode == 1) || (ser_mode == 0 && $urandom_range(0, 5) == 0);
    if (silent) begin
      for (int i = 1; i < TO; i++) begin
        @(negedge clk);
        if (reset) return;
      end
      check("err_before_timeout", err_timeout, exp_err);
      check("busy_wait_start", busy, 1);
      @(negedge clk);
      if (reset) return;
      check("err_at_timeout", err_timeout, 1);
      exp_err = 1'b1;
      ngap = GAP - 1;
    end else begin
      nbits = 8 * (int'(pi_length) + 1);
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        if (reset) return;
      end
      so_valid = 1'b1;
      for (int i = 0; i < nbits; i++) begin
        @(negedge clk);
        if (reset) begin
          so_valid = 1'b0;
          return;
        end
      end
      so_valid = 1'b0;
      exp_tx++;
      ngap = GAP;
    end
    for (int i = 0; i < ngap; i++) begin
      @(negedge clk);
      if (reset) return;
      check("busy_in_gap", busy, 1);
    end
    @(negedge clk);
    if (reset) return;
    check("idle_after_gap", busy, 0);
  endtask

  initial begin
    so_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        so_valid = 1'b0;
        exp_tx   = 0;
        exp_err  = 1'b0;
      end else if (load) begin
        ser_busy = 1'b1;
        run_ser();
        ser_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Requesters drop req once acknowledged.
  task automatic step();
    @(negedge clk);
    #1;
    if (a_ack) a_req = 1'b0;
    if (b_ack) b_req = 1'b0;
  endtask

  task automatic rand_a();
    a_data = 16'($urandom);
    a_len  = 2'($urandom_range(0, 3));
    {a_msb, a_low, a_fill} = 3'($urandom_range(0, 7));
  endtask

  task automatic rand_b();
    b_data = 16'($urandom);
    b_len  = 2'($urandom_range(0, 3));
    {b_msb, b_low, b_fill} = 3'($urandom_range(0, 7));
  endtask

  task automatic push_grant(input bit who, input int c);
    exp_t x;
    x.who  = who;
    x.desc = who ? {b_data, b_len, b_msb, b_low, b_fill} : {a_data, a_len, a_msb, a_low, a_fill};
    x.cyc  = c;
    exp_q.push_back(x);
  endtask

  // Raise requests and predict grant order with alternating priority.
  task automatic request(input bit ra, input bit rb, input int c);
    bit first;
    if (ra) a_req = 1'b1;
    if (rb) b_req = 1'b1;
    if (ra && rb) begin
      first = ~last_g;
      push_grant(first, c);
      push_grant(~first, -1);
      last_g = ~first;
    end else if (ra) begin
      push_grant(1'b0, c);
      last_g = 1'b0;
    end else if (rb) begin
      push_grant(1'b1, c);
      last_g = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int stable = 0;
    int budget = 0;
    while (stable < GAP + 4) begin
      step();
      budget++;
      if (exp_q.size() == 0 && !ser_busy && !a_req && !b_req) stable++;
      else stable = 0;
      if (budget > 2000) begin
        bound_fail("wait_idle");
        exp_q.delete();
        a_req = 1'b0;
        b_req = 1'b0;
        return;
      end
    end
  endtask

  task automatic wait_so_valid();
    int k = 0;
    while (!so_valid && k < 50) begin
      step();
      k++;
    end
    if (!so_valid) bound_fail("wait_so_valid");
  endtask

  initial begin
    int loads0;
    int k;
    reset = 1'b1;
    {a_req, a_msb, a_low, a_fill, a_end, b_req, b_msb, b_low, b_fill, b_end} = '0;
    a_data = '0; b_data = '0; a_len = '0; b_len = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_load", load, 0);
    check("rst_acks", {a_ack, b_ack}, 0);
    check("rst_busy", busy, 0);
    check("rst_tx", tx_count, 0);
    check("rst_pi", {pi_data, pi_length, pi_msb, pi_low, pi_fill}, 0);
    check("rst_flags", {grant_id, err_timeout, pi_end}, 0);
    reset = 1'b0;
    step();

    // Single A transfer with a known descriptor
    ser_mode = 2;
    a_data = 16'hA5C3; a_len = 2'd1; {a_msb, a_low, a_fill} = 3'b000;
    request(1'b1, 1'b0, cyc + 1);
    wait_idle();
    check("t1_tx", tx_count, 1);
    check("t1_pi_data", pi_data, 16'hA5C3);

    // Both requesting, four transfers
    for (int r = 0; r < 2; r++) begin
      rand_a(); rand_b();
      request(1'b1, 1'b1, cyc + 1);
      wait_idle();
    end
    check("t2_tx", tx_count, 8'(exp_tx));

    // Serializer never starts, then B still served
    ser_mode = 1;
    rand_a();
    request(1'b1, 1'b0, cyc + 1);
    wait_idle();
    check("t3_err_sticky", err_timeout, 1);
    check("t3_tx_unchanged", tx_count, 8'(exp_tx));
    ser_mode = 2;
    rand_b();
    request(1'b0, 1'b1, cyc + 1);
    wait_idle();
    check("t3_err_still", err_timeout, 1);

    // Randomized rounds
    ser_mode = 0;
    for (int r = 0; r < 25; r++) begin
      k = $urandom_range(1, 3);
      rand_a(); rand_b();
      request(k[0], k[1], cyc + 1);
      wait_idle();
      check("rand_tx", tx_count, 8'(exp_tx));
    end

    // Reset during WAIT_DONE with both requests pending
    ser_mode = 2;
    rand_a();
    request(1'b1, 1'b0, cyc + 1);
    wait_so_valid();
    step(); step();
    rand_a(); rand_b();
    a_req = 1'b1; b_req = 1'b1;
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_load", load, 0);
    check("mid_rst_pi_data", pi_data, 0);
    check("mid_rst_acks", {a_ack, b_ack}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx", tx_count, 0);
    exp_q.delete();
    last_g = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    request(1'b1, 1'b1, cyc + 1);
    wait_idle();
    check("post_rst_tx", tx_count, 8'(exp_tx));

    // End-of-stream: pending B served first, then pi_end and terminal END
    rand_a();
    request(1'b1, 1'b0, cyc + 1);
    wait_so_valid();
    a_end = 1'b1; step(); a_end = 1'b0;
    rand_b();
    request(1'b0, 1'b1, -1);
    step();
    b_end = 1'b1; step(); b_end = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || ser_busy) && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) bound_fail("end_wait");
    check("end_pi_end_in_idle", pi_end, 0);
    check("end_busy_idle", busy, 0);
    step();
    check("end_pi_end_set", pi_end, 1);
    check("end_busy", busy, 0);
    loads0 = loads_seen;
    rand_a();
    a_req = 1'b1;
    repeat (10) step();
    check("end_no_load", loads_seen, loads0);
    check("end_pi_end_sticky", pi_end, 1);
    check("end_tx", tx_count, 8'(exp_tx));
    check("end_err", err_timeout, exp_err);
    a_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sti_load_sched.md
Name: sti_load_sched

Overview:
- Round-robin scheduler that shares one STI/DAC serializer (load / pi_* / pi_end interface) between two requesters, A and B.
- Per transfer it latches a descriptor, issues a one-cycle load pulse, and holds pi_* stable for the whole transfer.
- It tracks completion from so_valid, enforces an inter-transfer gap, and asserts pi_end once both requesters have signalled end.
- A watchdog flags a serializer that never starts.

Parameters:
GAP_CYCLES, 1, idle cycles between so_valid falling and the next grant (1..15)
TIMEOUT, 16, max cycles in WAIT_START before err_timeout (2..255)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high
a_req  in  1  requester A has a descriptor pending; held until a_ack
a_data  in  16  A descriptor: parallel data
a_len  in  2  A descriptor: 0=8,1=16,2=24,3=32 bits
a_msb, a_low, a_fill  in  1 each  A descriptor: serializer mode bits
a_end  in  1  A end-of-stream pulse
a_ack  out  1  one-cycle grant acknowledge to A
b_req, b_data, b_len, b_msb, b_low, b_fill, b_end, b_ack  —  same as A, for B
so_valid  in  1  serializer output-valid, observed for completion
load  out  1  one-cycle start pulse to serializer
pi_data  out  16  latched descriptor data
pi_length  out  2  latched length
pi_msb, pi_low, pi_fill  out  1 each  latched mode bits
pi_end  out  1  end-of-stream to serializer, sticky
busy  out  1  high in any state except IDLE/END
grant_id  out  1  0=A, 1=B, owner of current/last transfer
err_timeout  out  1  sticky watchdog error
tx_count  out  8  completed transfers, wraps 255->0

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; last-grant pointer=B, so A wins first; end_a_seen=end_b_seen=0; gap and watchdog counters 0.
- States: IDLE, WAIT_START, WAIT_DONE, GAP, END.
- IDLE, any req high, pi_end=0:
  - Winner: the sole requester; if both request, the one not equal to last-grant.
  - On the clock edge: pi_* <= winner descriptor; load<=1; winner ack<=1; grant_id<=winner; last-grant<=winner; -> WAIT_START.
  - Latency req->load/ack: 1 cycle.
- load and ack are single-cycle pulses (0 in every cycle after issue). Requesters hold descriptors stable while req=1 and may keep req high after ack.
- A req seen in non-IDLE states is not acknowledged; it is considered at the next IDLE.
- WAIT_START:
  - Watchdog counts each cycle.
  - so_valid=1 -> WAIT_DONE, watchdog cleared.
  - Watchdog reaching TIMEOUT with so_valid=0 -> err_timeout<=1 (sticky until reset), tx_count unchanged, -> GAP.
- WAIT_DONE: so_valid=0 -> tx_count<=tx_count+1, -> GAP. No length check; the serializer owns bit count (8*(len+1) valid cycles).
- pi_data/pi_length/pi_msb/pi_low/pi_fill change only at issue; they are held through WAIT_START, WAIT_DONE, GAP and IDLE.
- GAP: stays exactly GAP_CYCLES cycles, then -> IDLE.
- End handling:
  - a_end / b_end pulses set end_a_seen / end_b_seen in any state, including the same cycle as a grant.
  - In IDLE with both seen and no req high: pi_end<=1, -> END.
  - END is terminal until reset: no acks, busy=0, load=0.
  - If both ends are seen but a req is still pending, that req is served first.
- busy = (state != IDLE && state != END), registered with the state.
- Reset asserted mid-transfer aborts immediately: load, pi_* and acks go to 0, and pending requests are re-arbitrated from A after reset release.

Test Plan:
1. Only a_req, a_data=16'hA5C3, a_len=1, serializer model holds so_valid 16 cycles -> load and a_ack high exactly 1 cycle after a_req; pi_data=16'hA5C3 stable until the next issue; tx_count=1; back in IDLE 1 cycle after so_valid falls (GAP_CYCLES=1).
2. a_req and b_req asserted together and held for 4 transfers -> grant order A,B,A,B; grant_id toggles; each ack single-cycle; tx_count=4.
3. Serializer never raises so_valid, TIMEOUT=16 -> err_timeout rises 16 cycles after load and stays 1; a subsequent b_req is still granted; tx_count unchanged by the failed transfer.
4. a_end pulsed mid-transfer, b_end pulsed while b_req pending -> b transfer completes first, then pi_end=1 one cycle later in IDLE; later a_req gets no ack and load stays 0.
5. reset asserted during WAIT_DONE -> load, pi_data, acks, busy, tx_count all 0 immediately; after release a pending a_req and b_req resolve with A granted first.
